// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execution unit for one issue slot.
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kills an in-flight MUL and any pending result (valid only)
//   in_valid/in_ready     issue-side handshake
//   alusignals            one-hot op select (add ld st sub mul cmp mov or and not lsl lsr)
//   op1, op2, immx        operands; B = sext(immx) when isimmediate, else op2
//   in_tag / out_tag      tag carried with the op
//   out_valid/out_ready   writeback-side handshake
//   aluresult, out_zero, out_neg, out_carry, out_err   registered result and flags
// Single-cycle ops complete at the accepting edge. MUL runs MUL_CYCLES
// shift-and-add steps of WIDTH/MUL_CYCLES multiplier bits each.
module alu_exec_unit #(
  parameter int WIDTH      = 16,
  parameter int IMM_W      = 5,
  parameter int TAG_W      = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      alusignals,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [IMM_W-1:0] immx,
  input  logic             isimmediate,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluresult,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_err
);

  localparam int STEP_W = WIDTH / MUL_CYCLES;
  localparam int CNT_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] STEP_MASK = WIDTH'((1 << STEP_W) - 1);

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ma_q, ma_d;     // multiplicand, pre-shifted for the current step
  logic [WIDTH-1:0] mb_q, mb_d;     // multiplier, consumed STEP_W bits per step
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [TAG_W-1:0] mtag_q, mtag_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, err_q, err_d;

  logic [WIDTH-1:0] b_val;
  logic [WIDTH:0]   sum_w, diff_w;
  logic             is_onehot, accept;
  logic [WIDTH-1:0] alu_res, mul_part, mul_res;
  logic             alu_carry;

  function automatic logic [WIDTH-1:0] shift_l(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] sh);
    return (sh >= WIDTH_V) ? '0 : (a << sh);
  endfunction

  function automatic logic [WIDTH-1:0] shift_r(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] sh);
    return (sh >= WIDTH_V) ? '0 : (a >> sh);
  endfunction

  assign b_val     = isimmediate ? {{(WIDTH-IMM_W){immx[IMM_W-1]}}, immx} : op2;
  assign is_onehot = (alusignals != 12'd0) && ((alusignals & (alusignals - 12'd1)) == 12'd0);
  // Slot must be empty or draining this cycle so any result has somewhere to land.
  assign in_ready  = (state_q == S_IDLE) && !flush && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;

  assign sum_w  = {1'b0, op1} + {1'b0, b_val};
  // Subtract as op1 + ~B + 1 so the carry-out means "no borrow".
  assign diff_w = {1'b0, op1} + {1'b0, ~b_val} + {{WIDTH{1'b0}}, 1'b1};

  assign mul_part = ma_q * (mb_q & STEP_MASK);
  assign mul_res  = acc_q + mul_part;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    if (is_onehot) begin
      if (alusignals[0] || alusignals[1] || alusignals[2]) begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end else if (alusignals[3] || alusignals[5]) begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
      end else if (alusignals[6])  alu_res = b_val;
      else if (alusignals[7])      alu_res = op1 | b_val;
      else if (alusignals[8])      alu_res = op1 & b_val;
      else if (alusignals[9])      alu_res = ~b_val;
      else if (alusignals[10])     alu_res = shift_l(op1, b_val);
      else if (alusignals[11])     alu_res = shift_r(op1, b_val);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    acc_d       = acc_q;
    mtag_d      = mtag_q;
    out_valid_d = out_valid_q && !out_ready;
    res_d       = res_q;
    tag_d       = tag_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    err_d       = err_q;
    if (flush) begin
      // Only valid is cleared; result/tag/flag registers keep their contents.
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_onehot && alusignals[4]) begin
              state_d = S_MUL_BUSY;
              cnt_d   = '0;
              ma_d    = op1;
              mb_d    = b_val;
              acc_d   = '0;
              mtag_d  = in_tag;
            end else begin
              out_valid_d = 1'b1;
              res_d       = alu_res;
              tag_d       = in_tag;
              zero_d      = (alu_res == '0);
              neg_d       = alu_res[WIDTH-1];
              carry_d     = alu_carry;
              err_d       = !is_onehot;
            end
          end
        end
        S_MUL_BUSY: begin
          acc_d = mul_res;
          ma_d  = ma_q << STEP_W;
          mb_d  = mb_q >> STEP_W;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            res_d       = mul_res;
            tag_d       = mtag_q;
            zero_d      = (mul_res == '0);
            neg_d       = mul_res[WIDTH-1];
            carry_d     = 1'b0;
            err_d       = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      mtag_q      <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      tag_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      mtag_q      <= mtag_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      tag_q       <= tag_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign aluresult = res_q;
  assign out_tag   = tag_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign out_carry = carry_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus randomized traffic, checked
// against a transaction-level model (op results from plain arithmetic, MUL as
// a countdown of remaining busy cycles, one-entry output slot).
module tb_alu_exec_unit;
  localparam int W  = 16;
  localparam int IW = 5;
  localparam int TW = 4;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [11:0]   alusignals = '0;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  logic [IW-1:0] immx = '0;
  logic          isimmediate = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  aluresult;
  logic [TW-1:0] out_tag;
  logic          out_zero, out_neg, out_carry, out_err;

  alu_exec_unit #(.WIDTH(W), .IMM_W(IW), .TAG_W(TW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alusignals(alusignals), .op1(op1), .op2(op2), .immx(immx),
    .isimmediate(isimmediate), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluresult(aluresult), .out_tag(out_tag),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  int            m_busy = 0;
  bit            m_ovalid = 1'b0;
  logic [W-1:0]  m_res = '0, p_res = '0;
  logic [TW-1:0] m_tag = '0, p_tag = '0;
  bit            m_carry = 1'b0, m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_op(input logic [11:0] alu, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output bit c, output bit e);
    int ai, bi;
    longint p;
    ai = int'(a);
    bi = int'(b);
    r = '0; c = 1'b0; e = 1'b0;
    case (alu)
      12'h001, 12'h002, 12'h004: begin r = W'(ai + bi); c = (ai + bi) > 65535; end
      12'h008, 12'h020:          begin r = W'(ai - bi); c = (ai >= bi); end
      12'h010:                   begin p = longint'(ai) * longint'(bi); r = W'(p); end
      12'h040: r = b;
      12'h080: r = a | b;
      12'h100: r = a & b;
      12'h200: r = ~b;
      12'h400: r = (bi >= W) ? '0 : W'(ai << bi);
      12'h800: r = (bi >= W) ? '0 : W'(ai >> bi);
      default: e = 1'b1;
    endcase
  endtask

  // One clock cycle: drive, check everything against the model, advance, update model.
  task automatic cyc(input bit iv, input logic [11:0] alu, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [IW-1:0] imm, input bit isi,
                     input logic [TW-1:0] tg, input bit ordy, input bit fl);
    logic [W-1:0] bv, r;
    bit c, e, exp_rdy, acc;
    in_valid = iv; alusignals = alu; op1 = a; op2 = b; immx = imm;
    isimmediate = isi; in_tag = tg; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (m_busy == 0) && !fl && (!m_ovalid || ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ovalid);
    if (m_ovalid) begin
      chk("aluresult", aluresult, m_res);
      chk("out_tag", out_tag, m_tag);
      chk("out_zero", out_zero, m_res == '0);
      chk("out_neg", out_neg, m_res[W-1]);
      chk("out_carry", out_carry, m_carry);
      chk("out_err", out_err, m_err);
    end
    acc = iv && exp_rdy;
    bv  = isi ? {{(W-IW){imm[IW-1]}}, imm} : b;
    ref_op(alu, a, bv, r, c, e);
    @(posedge clk);
    if (fl) begin
      m_ovalid = 1'b0;
      m_busy   = 0;
    end else begin
      if (m_ovalid && ordy) m_ovalid = 1'b0;
      if (acc) begin
        if (alu == 12'h010) begin
          m_busy = MC; p_res = r; p_tag = tg;
        end else begin
          m_ovalid = 1'b1; m_res = r; m_tag = tg; m_carry = c; m_err = e;
        end
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ovalid = 1'b1; m_res = p_res; m_tag = p_tag; m_carry = 1'b0; m_err = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'h000, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [11:0] ralu;
    logic [W-1:0] ra, rb;
    int k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_res", aluresult, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", {out_zero, out_neg, out_carry, out_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD
    cyc(1, 12'h001, 16'h0005, 16'h0003, '0, 0, 4'h7, 1, 0);
    chk("add_res", aluresult, 16'h0008);
    chk("add_zero", out_zero, 0);
    chk("add_carry", out_carry, 0);
    chk("add_tag", out_tag, 4'h7);
    // SUB
    cyc(1, 12'h008, 16'h0003, 16'h0005, '0, 0, 4'h2, 1, 0);
    chk("sub_res", aluresult, 16'hFFFE);
    chk("sub_neg", out_neg, 1);
    chk("sub_carry", out_carry, 0);
    // CMP equal
    cyc(1, 12'h020, 16'h1234, 16'h1234, '0, 0, 4'h3, 1, 0);
    chk("cmp_res", aluresult, 16'h0000);
    chk("cmp_zero", out_zero, 1);
    chk("cmp_carry", out_carry, 1);
    // LSL immediate
    cyc(1, 12'h400, 16'h0005, 16'hAAAA, 5'b00011, 1, 4'h4, 1, 0);
    chk("lsl_imm", aluresult, 16'h0028);
    // Shift overflow
    cyc(1, 12'h400, 16'h0005, 16'h0010, '0, 0, 4'h5, 1, 0);
    chk("lsl_ovf", aluresult, 16'h0000);
    // Illegal op
    cyc(1, 12'h003, 16'h0005, 16'h0003, '0, 0, 4'h6, 1, 0);
    chk("ill_err", out_err, 1);
    chk("ill_res", aluresult, 16'h0000);
    chk("ill_zero", out_zero, 1);

    // MUL 5*3
    cyc(1, 12'h010, 16'h0005, 16'h0003, '0, 0, 4'h8, 1, 0);
    idle(MC);
    chk("mul_valid", out_valid, 1);
    chk("mul_res", aluresult, 16'h000F);
    chk("mul_tag", out_tag, 4'h8);
    // MUL FFFF*FFFF
    cyc(1, 12'h010, 16'hFFFF, 16'hFFFF, '0, 0, 4'h9, 1, 0);
    idle(MC);
    chk("mul_ff", aluresult, 16'h0001);

    // Backpressure: hold an ADD result for 3 cycles while a SUB waits
    cyc(1, 12'h001, 16'h0100, 16'h0023, '0, 0, 4'hA, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 12'h008, 16'h0050, 16'h0010, '0, 0, 4'hB, 0, 0);
      chk("bp_hold", aluresult, 16'h0123);
      chk("bp_tag", out_tag, 4'hA);
    end
    cyc(1, 12'h008, 16'h0050, 16'h0010, '0, 0, 4'hB, 1, 0);
    chk("bp_next", aluresult, 16'h0040);
    chk("bp_next_tag", out_tag, 4'hB);
    cyc(1, 12'h080, 16'h0F00, 16'h00F0, '0, 0, 4'hC, 1, 0);
    chk("b2b", aluresult, 16'h0FF0);
    chk("b2b_valid", out_valid, 1);

    // Flush during MUL
    cyc(1, 12'h010, 16'h0007, 16'h0006, '0, 0, 4'hD, 1, 0);
    idle(1);
    cyc(0, 12'h000, '0, '0, '0, 0, '0, 1, 1);
    out_ready = 1'b1; flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_rdy", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    #1;
    idle(MC + 2);

    // Reset pulse during MUL
    cyc(1, 12'h001, 16'h0011, 16'h0022, '0, 0, 4'hE, 1, 0);
    cyc(1, 12'h010, 16'h0009, 16'h0009, '0, 0, 4'hF, 1, 0);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("rmid_valid", out_valid, 0);
    chk("rmid_res", aluresult, 0);
    chk("rmid_tag", out_tag, 0);
    chk("rmid_flags", {out_zero, out_neg, out_carry, out_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_busy = 0; m_ovalid = 1'b0;
    idle(MC + 2);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 13);
      if (k < 12)       ralu = 12'(1 << k);
      else if (k == 12) ralu = 12'h000;
      else              ralu = 12'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      cyc($urandom_range(0, 9) < 7, ralu, ra, rb, IW'($urandom), $urandom_range(0, 1) == 1,
          TW'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    idle(MC + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
